// File: rtl/sram_arb_ctrl.sv
// SRAM arbiter and pipeline stall generator.
// One 32-bit asynchronous SRAM is shared between instruction fetch (IF) and data access (MEM).
// MEM has priority, and accesses are never preempted. Every access holds the strobes for
// WAIT_CYCLES+1 cycles. The block also produces the per-stage STALL vector and buffers a
// fetched word while the IF stage is stopped by MEM or EX.
// Optional: define SRAM_ARB_PERF_EN to add the IF_STALL_CNT / MEM_STALL_CNT stall counters.
module sram_arb_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IF_REQ,
  input  logic [31:0] IF_ADDR,
  output logic [31:0] IF_RDATA,
  input  logic        MEM_REQ,
  input  logic        MEM_WE,
  input  logic [3:0]  MEM_BE,
  input  logic [31:0] MEM_ADDR,
  input  logic [31:0] MEM_WDATA,
  output logic [31:0] MEM_RDATA,
  input  logic        STALLREQ_EX,
  input  logic        FLUSH,
  output logic [4:0]  STALL,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [3:0]  SRAM_BE_N,
  output logic [31:0] SRAM_DQ_O,
  input  logic [31:0] SRAM_DQ_I,
  output logic        SRAM_DQ_T
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [31:0] IF_STALL_CNT,
  output logic [31:0] MEM_STALL_CNT
`endif
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACC_MEM = 2'd1;
  localparam logic [1:0] ACC_IF  = 2'd2;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        discard_q, discard_d;
  logic        if_buf_valid_q, if_buf_valid_d;
  logic [31:0] if_buf_q, if_buf_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;

  logic acc_mem, acc_if, acc, last, mem_last, if_last, if_last_ok;
  logic mem_pend, if_pend, if_avail, wr;

  // Only the word address within the 4 MiB SRAM window reaches the pins.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IF_ADDR[31:22], IF_ADDR[1:0], MEM_ADDR[31:22], MEM_ADDR[1:0]};

  // Access decode, pending requests and the stall vector.
  always_comb begin
    acc_mem    = (state_q == ACC_MEM);
    acc_if     = (state_q == ACC_IF);
    acc        = acc_mem | acc_if;
    last       = acc && (cnt_q == 4'd0);
    mem_last   = acc_mem && (cnt_q == 4'd0);
    if_last    = acc_if && (cnt_q == 4'd0);
    // A fetch flushed while in flight still completes but its word is thrown away.
    if_last_ok = if_last && !discard_q;
    mem_pend   = MEM_REQ && !mem_last;
    if_avail   = if_last_ok || if_buf_valid_q;
    if_pend    = IF_REQ && !if_avail;
    wr         = acc_mem && MEM_WE;
    STALL      = ({5{mem_pend}} & 5'b01111) | ({5{STALLREQ_EX}} & 5'b00111) |
                 {4'b0000, if_pend};
  end

  // Arbitration in IDLE and on each last cycle, so accesses can run back to back.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE || last) begin
      // mem_pend excludes a MEM request finishing now; if_pend excludes a fetch finishing now.
      if (mem_pend) begin
        state_d = ACC_MEM;
        cnt_d   = WAIT_INIT;
      end else if (if_pend) begin
        state_d = ACC_IF;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Discard flag, IF hold buffer and read-data registers.
  always_comb begin
    discard_d      = discard_q;
    if_buf_valid_d = if_buf_valid_q;
    if_buf_d       = if_buf_q;
    if_rdata_d     = if_rdata_q;
    mem_rdata_d    = mem_rdata_q;

    if (if_last) begin
      discard_d = 1'b0;
    end else if (FLUSH && acc_if) begin
      discard_d = 1'b1;
    end

    if (FLUSH) begin
      if_buf_valid_d = 1'b0;
    end else if (if_last_ok && STALL[0]) begin
      // Fetch finished while MEM or EX holds the IF stage: keep the word until it moves.
      if_buf_valid_d = 1'b1;
      if_buf_d       = SRAM_DQ_I;
    end else if (!STALL[0]) begin
      if_buf_valid_d = 1'b0;
    end

    if (if_last) begin
      if_rdata_d = SRAM_DQ_I;
    end
    if (mem_last && !MEM_WE) begin
      mem_rdata_d = SRAM_DQ_I;
    end
  end

  // SRAM pin strobes and read-data outputs.
  always_comb begin
    SRAM_CE_N = !acc;
    SRAM_OE_N = !(acc && !wr);
    SRAM_WE_N = !wr;
    SRAM_DQ_T = !wr;
    SRAM_DQ_O = wr ? MEM_WDATA : 32'h0;
    if (wr) begin
      SRAM_BE_N = ~MEM_BE;
    end else if (acc) begin
      SRAM_BE_N = 4'h0;
    end else begin
      SRAM_BE_N = 4'hF;
    end
    if (acc_mem) begin
      SRAM_ADDR = MEM_ADDR[21:2];
    end else if (acc_if) begin
      SRAM_ADDR = IF_ADDR[21:2];
    end else begin
      SRAM_ADDR = 20'h0;
    end
    if (if_buf_valid_q) begin
      IF_RDATA = if_buf_q;
    end else if (if_last) begin
      IF_RDATA = SRAM_DQ_I;
    end else begin
      IF_RDATA = if_rdata_q;
    end
    MEM_RDATA = (mem_last && !MEM_WE) ? SRAM_DQ_I : mem_rdata_q;
  end

  // State registers with synchronous reset; reset abandons any access in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      discard_q      <= 1'b0;
      if_buf_valid_q <= 1'b0;
      if_buf_q       <= 32'h0;
      if_rdata_q     <= 32'h0;
      mem_rdata_q    <= 32'h0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      discard_q      <= discard_d;
      if_buf_valid_q <= if_buf_valid_d;
      if_buf_q       <= if_buf_d;
      if_rdata_q     <= if_rdata_d;
      mem_rdata_q    <= mem_rdata_d;
    end
  end

`ifdef SRAM_ARB_PERF_EN
  logic [31:0] if_stall_cnt_q, if_stall_cnt_d;
  logic [31:0] mem_stall_cnt_q, mem_stall_cnt_d;

  // Saturating stall-cycle counters; a fetch stall hidden behind a MEM stall is not counted.
  always_comb begin
    if_stall_cnt_d  = if_stall_cnt_q;
    mem_stall_cnt_d = mem_stall_cnt_q;
    if (if_pend && !mem_pend && (if_stall_cnt_q != 32'hFFFF_FFFF)) begin
      if_stall_cnt_d = if_stall_cnt_q + 32'd1;
    end
    if (mem_pend && (mem_stall_cnt_q != 32'hFFFF_FFFF)) begin
      mem_stall_cnt_d = mem_stall_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if_stall_cnt_q  <= 32'h0;
      mem_stall_cnt_q <= 32'h0;
    end else begin
      if_stall_cnt_q  <= if_stall_cnt_d;
      mem_stall_cnt_q <= mem_stall_cnt_d;
    end
  end

  assign IF_STALL_CNT  = if_stall_cnt_q;
  assign MEM_STALL_CNT = mem_stall_cnt_q;
`endif

endmodule

// File: doc/sram_arb_ctrl.md
Name: sram_arb_ctrl

Overview:
- Arbitrates one external 32-bit asynchronous SRAM between instruction fetch (IF) and data access (MEM).
- Sequences each SRAM access over a fixed number of wait cycles.
- Generates the per-stage STALL vector that drives the pipeline registers, including the IF/ID register's bubble-insertion behaviour.
- Sits between the pipeline stages, the EX multicycle units and the SRAM pins.

Parameters:
WAIT_CYCLES, 1, extra cycles each SRAM access is held; every access lasts WAIT_CYCLES+1 cycles; legal range 0..15.

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
IF_REQ  in  1  fetch request, held until the word is delivered
IF_ADDR  in  32  fetch byte address
IF_RDATA  out  32  fetched instruction word
MEM_REQ  in  1  data access request, held until done
MEM_WE  in  1  1 = write, 0 = read
MEM_BE  in  4  byte enables for writes
MEM_ADDR  in  32  data byte address
MEM_WDATA  in  32  write data
MEM_RDATA  out  32  read data
STALLREQ_EX  in  1  EX multicycle unit busy
FLUSH  in  1  branch/exception flush of the fetch path
STALL  out  5  stop per stage: [0] IF, [1] ID, [2] EX, [3] MEM, [4] WB; 1 = stop
SRAM_ADDR  out  20  word address, equal to addr[21:2]
SRAM_CE_N, SRAM_OE_N, SRAM_WE_N  out  1 each  active-low strobes
SRAM_BE_N  out  4  active-low byte enables
SRAM_DQ_O  out  32  write data to the pad
SRAM_DQ_I  in  32  read data from the pad
SRAM_DQ_T  out  1  1 = pad tristated (read)

Behaviour:
- Reset: state IDLE, counter 0, STALL=0, CE_N=OE_N=WE_N=1, BE_N=4'hF, SRAM_ADDR=0, DQ_O=0, DQ_T=1, IF_RDATA=0, MEM_RDATA=0, IF buffer invalid, discard flag 0. RST mid-access abandons the access immediately.
- FSM states:
  - IDLE: all strobes inactive.
  - ACC_MEM: load counter with WAIT_CYCLES.
  - ACC_IF: load counter with WAIT_CYCLES.
- Counter decrements each cycle in an ACC state. The cycle with counter==0 is the last cycle.
- Arbitration:
  - Checked in IDLE and on the last cycle, so back-to-back accesses have no idle gap.
  - MEM has priority.
  - IF is served only if IF_REQ=1, the IF buffer is invalid and MEM_REQ=0.
  - Accesses are non-preemptive.
- Strobes during an ACC state:
  - CE_N=0; SRAM_ADDR taken from the owner's address.
  - Read: OE_N=0, WE_N=1, BE_N=0, DQ_T=1.
  - Write: OE_N=1, WE_N=0, BE_N=~MEM_BE, DQ_T=0, DQ_O=MEM_WDATA.
- Read data on the last cycle:
  - The owner's RDATA is SRAM_DQ_I combinationally on that cycle, and is registered for all later cycles.
  - MEM_RDATA is unchanged by writes.
- mem_pend = MEM_REQ and the MEM access is not on its last cycle.
- if_pend = IF_REQ and fetch data is not available this cycle. Fetch data is available on the IF last cycle, or when the IF buffer is valid.
- STALL is combinational, OR of three sources:
  - mem_pend gives 5'b01111.
  - STALLREQ_EX gives 5'b00111.
  - if_pend gives 5'b00001. IF stopped with ID running makes the IF/ID register insert a bubble.
- IF buffer:
  - An IF last cycle while STALL[0]=1 (caused by MEM or EX) stores DQ_I into the buffer and sets it valid.
  - IF_RDATA = buffer while valid.
  - The buffer is cleared on the first cycle with STALL[0]=0.
- FLUSH:
  - Clears the IF buffer.
  - Sets the discard flag if an IF access is in flight. A discarded IF last cycle does not count as data available; if_pend stays 1 and a new fetch is issued.
  - MEM accesses are never aborted.
- MEM_REQ and IF_REQ asserted in the same IDLE cycle: MEM first, IF issued back-to-back after it.

Optional Feature:
- Macro SRAM_ARB_PERF_EN.
- Defined: adds outputs IF_STALL_CNT[31:0] and MEM_STALL_CNT[31:0].
  - IF_STALL_CNT counts cycles with if_pend=1 and mem_pend=0.
  - MEM_STALL_CNT counts cycles with mem_pend=1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: these ports and their logic are absent.

Test Plan:
- WAIT_CYCLES=1, IF_REQ held, addr 0x80000004, DQ_I=0x24010005 -> SRAM_ADDR=0x00001, OE_N=0 for 2 cycles, STALL=00001 then 00000, IF_RDATA=0x24010005 on the 2nd cycle.
- MEM write, addr 0x80000010, BE=4'b0011, data 0xDEADBEEF -> WE_N=0, BE_N=4'b1100, DQ_T=0, DQ_O=0xDEADBEEF for 2 cycles, STALL=01111 then 00000.
- IF_REQ and MEM read (DQ_I=0x12345678) in the same cycle -> MEM served first with MEM_RDATA=0x12345678, then IF back-to-back with no idle cycle between accesses.
- STALLREQ_EX=1 for 3 cycles during an IF access -> STALL=00111, completed fetch word held in the buffer, delivered with STALL=00000 once EX releases and no new SRAM access issued.
- FLUSH on the 1st cycle of an IF access (WAIT_CYCLES=2) -> the access completes with data discarded and STALL[0] held 1, then a new fetch of the new IF_ADDR is issued.
- RST asserted mid MEM write -> next cycle WE_N=1, CE_N=1, DQ_T=1, STALL=0.
